mpu_thread_dispatch: RTL and testbench
======================================

// Module: mpu_thread_dispatch
// PURPOSE
//  Downstream neighbour of the MPU thread memory. Queues ready-thread IDs pulsed by thread memory and resolves each
//  via MapMan to {start,length}. Streams the thread's instructions out of thread memory (registered read, latency 1)
//  and forwards them to the TPU with stall back-pressure, marking end-of-thread.
// PARAMETERS
//  SIZE_THREAD_MEM  1024  instruction-memory entries; power of 2; address wraps modulo this
//  WIDTH_ADDR       10    $clog2(SIZE_THREAD_MEM); width of address/length fields
//  WIDTH_INSTR      64    instruction word width
//  WIDTH_ID         8     thread-ID width
//  DEPTH_PEND       4     pending-ID queue depth; power of 2, >=2
// PORTS
//  clock           in   1            single clock, rising edge
//  reset           in   1            asynchronous, active-low (0 = reset)
//  I_Req           in   1            one-cycle pulse: thread ready (from thread memory O_Req)
//  I_ThreadID      in   WIDTH_ID     ID qualified by I_Req
//  O_Req_Lookup    out  1            lookup request to MapMan; held until ack
//  O_ThreadID_Lk   out  WIDTH_ID     ID being looked up
//  I_Ack_Lookup    in   1            MapMan ack; qualifies I_Start/I_Length
//  I_Start         in   WIDTH_ADDR   thread start address
//  I_Length        in   WIDTH_ADDR   number of instructions (0 = empty thread)
//  O_Req_Ld        out  1            load request to thread memory
//  O_Address_Ld    out  WIDTH_ADDR   load address
//  I_Instr_Ld      in   WIDTH_INSTR  instruction, valid 1 cycle after address issued
//  O_Send          out  1            instruction valid to TPU
//  O_Instr         out  WIDTH_INSTR  instruction to TPU
//  O_End           out  1            pulse with final instruction (or alone for empty thread)
//  O_ThreadID      out  WIDTH_ID     ID of thread being sent
//  I_Stall         in   1            TPU back-pressure
//  O_Busy          out  1            FSM not IDLE or queue non-empty
//  O_Overflow      out  1            sticky: ID dropped on full queue
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, queue empty, counters 0; asynchronous assert mid-thread abandons thread.
//  Queue: push on I_Req; pop on IDLE->LOOKUP. Push+pop same cycle always accepted, even when full.
//    Push on full with no pop: ID dropped, O_Overflow<=1 until reset.
//  FSM IDLE: queue non-empty -> LOOKUP (pop into R_ThreadID).
//  FSM LOOKUP: O_Req_Lookup=1. On I_Ack_Lookup: R_Addr<=I_Start, R_Remain<=I_Length.
//    Length 0 -> END. Else -> LOAD.
//  FSM LOAD: O_Req_Ld=1 continuously, even during stall; no mid-thread drop, since thread memory counts rising edges.
//    Issue when ~I_Stall: R_Addr<=R_Addr+1 (mod SIZE_THREAD_MEM), R_Remain<=R_Remain-1, R_Vld<=1.
//    Issuing last word (R_Remain==1) -> DRAIN. Stalled cycle: R_Vld<=0, address held.
//  FSM DRAIN: O_Req_Ld=0; last word delivered this cycle -> END.
//  FSM END: O_End=1 for one cycle -> IDLE.
//    Guarantees O_Req_Ld low >=2 cycles between threads.
//  Output: O_Send=R_Vld; O_Instr=I_Instr_Ld; O_End coincides with O_Send of final word (DRAIN cycle);
//    for empty thread, O_End pulses alone in END.
//  Stall: I_Stall seen at cycle t blocks issue at t; word issued at t-1 still appears at t.
//    TPU must absorb one word after asserting stall.
//  Latency: ack -> first O_Send = 2 cycles. Unstalled throughput 1 word/cycle.
//  O_ThreadID=R_ThreadID throughout LOOKUP..END.
// CONFIGURATION
//  MPU_DISPATCH_PERF_EN defined: adds outputs O_Perf_Threads[31:0] (+1 per END) and O_Perf_Stall[31:0]
//    (+1 per LOAD cycle with I_Stall). Both saturate at all-ones; reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 I_Req ID=5; ack start=0x10 len=3 -> O_Address_Ld 0x10,0x11,0x12; O_Send words 0-2 on consecutive cycles.
//     O_End with word 2; O_Req_Ld low 2 cycles after.
//  T2 start=0x3FE len=4 -> addresses 0x3FE,0x3FF,0x000,0x001 (wrap).
//  T3 len=5, I_Stall high 3 cycles after 2nd issue -> exactly 1 word in stall window, 5 words total, none dup/lost.
//     O_Req_Ld stays 1 throughout.
//  T4 len=0 ack -> no O_Req_Ld, O_Send=0, O_End single pulse, FSM back to IDLE.
//  T5 6 I_Req pulses while first thread loading (DEPTH_PEND=4) -> 4 queued, 1 in service, O_Overflow=1.
//     Queued IDs dispatched in FIFO order.
//  T6 reset=0 mid-LOAD -> all outputs 0 asynchronously, queue empty; after release, new I_Req dispatches normally.

Source files
------------

// File: rtl/mpu_thread_dispatch.sv
// Thread dispatcher: queues ready thread IDs, resolves each through MapMan, streams its words to the TPU (MPU_DISPATCH_PERF_EN adds perf counters).
// Latency: lookup ack to first O_Send is 2 cycles; 1 word/cycle when unstalled; O_End rides with the final word.
// Backpressure: I_Stall blocks the next issue; the word already read out of thread memory still appears next cycle.

// Pending-ID queue; a push into a full queue is still accepted when a pop happens in the same cycle.
// Latency: 1 cycle from push to head visibility; pop reads the head combinationally.
// Backpressure: none upstream; a push on full without pop is dropped and flagged.
module mpu_dispatch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign dropped  = push && full && !pop;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, a simultaneous pop frees the head slot that wr_ptr now points at.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module mpu_thread_dispatch #(
    parameter int SIZE_THREAD_MEM = 1024,
    parameter int WIDTH_ADDR      = 10,
    parameter int WIDTH_INSTR     = 64,
    parameter int WIDTH_ID        = 8,
    parameter int DEPTH_PEND      = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_Req,
    input  logic [WIDTH_ID-1:0]    I_ThreadID,
    output logic                   O_Req_Lookup,
    output logic [WIDTH_ID-1:0]    O_ThreadID_Lk,
    input  logic                   I_Ack_Lookup,
    input  logic [WIDTH_ADDR-1:0]  I_Start,
    input  logic [WIDTH_ADDR-1:0]  I_Length,
    output logic                   O_Req_Ld,
    output logic [WIDTH_ADDR-1:0]  O_Address_Ld,
    input  logic [WIDTH_INSTR-1:0] I_Instr_Ld,
    output logic                   O_Send,
    output logic [WIDTH_INSTR-1:0] O_Instr,
    output logic                   O_End,
    output logic [WIDTH_ID-1:0]    O_ThreadID,
    input  logic                   I_Stall,
`ifdef MPU_DISPATCH_PERF_EN
    output logic [31:0]            O_Perf_Threads,
    output logic [31:0]            O_Perf_Stall,
`endif
    output logic                   O_Busy,
    output logic                   O_Overflow
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_DRAIN,
        S_END
    } state_t;

    state_t                state;
    logic [WIDTH_ID-1:0]   r_thread_id;
    logic [WIDTH_ADDR-1:0] r_addr;
    logic [WIDTH_ADDR-1:0] r_remain;
    logic                  r_vld;
    logic                  req_lookup;
    logic                  req_ld;
    logic                  end_pulse;
    logic                  overflow;

    logic                  q_pop;
    logic [WIDTH_ID-1:0]   q_head;
    logic                  q_empty;
    logic                  q_full;
    logic                  q_dropped;

    assign q_pop = (state == S_IDLE) && !q_empty;

    mpu_dispatch_fifo #(
        .WIDTH (WIDTH_ID),
        .DEPTH (DEPTH_PEND)
    ) u_pend (
        .clock    (clock),
        .reset    (reset),
        .push     (I_Req),
        .push_dat (I_ThreadID),
        .pop      (q_pop),
        .head_dat (q_head),
        .empty    (q_empty),
        .full     (q_full),
        .dropped  (q_dropped)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            r_thread_id <= '0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_vld       <= 1'b0;
            req_lookup  <= 1'b0;
            req_ld      <= 1'b0;
            end_pulse   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (q_dropped) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (!q_empty) begin
                        state       <= S_LOOKUP;
                        r_thread_id <= q_head;
                        req_lookup  <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (I_Ack_Lookup) begin
                        req_lookup <= 1'b0;
                        r_addr     <= I_Start;
                        r_remain   <= I_Length;
                        if (I_Length == '0) begin
                            state     <= S_END;
                            end_pulse <= 1'b1;
                        end else begin
                            state  <= S_LOAD;
                            req_ld <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Load request stays high while stalled: thread memory counts every edge with it set.
                    if (!I_Stall) begin
                        r_addr   <= WIDTH_ADDR'((int'(r_addr) + 1) % SIZE_THREAD_MEM);
                        r_remain <= r_remain - 1'b1;
                        r_vld    <= 1'b1;
                        if (r_remain == WIDTH_ADDR'(1)) begin
                            state     <= S_DRAIN;
                            req_ld    <= 1'b0;
                            end_pulse <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    state     <= S_END;
                    end_pulse <= 1'b0;
                end
                S_END: begin
                    state     <= S_IDLE;
                    end_pulse <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign O_Req_Lookup  = req_lookup;
    assign O_ThreadID_Lk = r_thread_id;
    assign O_Req_Ld      = req_ld;
    assign O_Address_Ld  = r_addr;
    assign O_Send        = r_vld;
    assign O_Instr       = r_vld ? I_Instr_Ld : '0;
    assign O_End         = end_pulse;
    assign O_ThreadID    = r_thread_id;
    assign O_Busy        = (state != S_IDLE) || !q_empty;
    assign O_Overflow    = overflow;

`ifdef MPU_DISPATCH_PERF_EN
    logic [31:0] perf_threads;
    logic [31:0] perf_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_threads <= '0;
            perf_stall   <= '0;
        end else begin
            if (state == S_END && perf_threads != '1) perf_threads <= perf_threads + 1'b1;
            if (state == S_LOAD && I_Stall && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
        end
    end

    assign O_Perf_Threads = perf_threads;
    assign O_Perf_Stall   = perf_stall;
`endif
endmodule

// File: tb/tb_mpu_thread_dispatch.sv
// Bench for mpu_thread_dispatch: thread memory and MapMan modelled as arrays, expected word stream queued per accepted ID.
module tb_mpu_thread_dispatch;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        I_Req = 1'b0;
    logic [7:0]  I_ThreadID = '0;
    logic        O_Req_Lookup;
    logic [7:0]  O_ThreadID_Lk;
    logic        I_Ack_Lookup = 1'b0;
    logic [9:0]  I_Start = '0;
    logic [9:0]  I_Length = '0;
    logic        O_Req_Ld;
    logic [9:0]  O_Address_Ld;
    logic [63:0] I_Instr_Ld = '0;
    logic        O_Send;
    logic [63:0] O_Instr;
    logic        O_End;
    logic [7:0]  O_ThreadID;
    logic        I_Stall = 1'b0;
    logic        O_Busy;
    logic        O_Overflow;
`ifdef MPU_DISPATCH_PERF_EN
    logic [31:0] perf_threads;
    logic [31:0] perf_stall;
`endif

    mpu_thread_dispatch dut (
        .clock         (clock),
        .reset         (reset),
        .I_Req         (I_Req),
        .I_ThreadID    (I_ThreadID),
        .O_Req_Lookup  (O_Req_Lookup),
        .O_ThreadID_Lk (O_ThreadID_Lk),
        .I_Ack_Lookup  (I_Ack_Lookup),
        .I_Start       (I_Start),
        .I_Length      (I_Length),
        .O_Req_Ld      (O_Req_Ld),
        .O_Address_Ld  (O_Address_Ld),
        .I_Instr_Ld    (I_Instr_Ld),
        .O_Send        (O_Send),
        .O_Instr       (O_Instr),
        .O_End         (O_End),
        .O_ThreadID    (O_ThreadID),
        .I_Stall       (I_Stall),
`ifdef MPU_DISPATCH_PERF_EN
        .O_Perf_Threads(perf_threads),
        .O_Perf_Stall  (perf_stall),
`endif
        .O_Busy        (O_Busy),
        .O_Overflow    (O_Overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        send;
        logic [63:0] instr;
        logic        last;
        logic [7:0]  id;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  addr_log[$];
    logic [63:0] tmem [1024];
    logic [9:0]  tbl_start [256];
    logic [9:0]  tbl_len [256];
    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;
    int send_cnt, end_cnt, ld_cyc, ld_after_end, post_end;
    int first_send_cyc, ack_cyc, lk_wait, outstanding;
    logic stall_rand = 1'b0;
    logic pr;
    logic [9:0] pa;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected TPU stream of one thread, built from the MapMan table and thread memory contents.
    task automatic enqueue(input logic [7:0] id);
        exp_t e;
        logic [9:0] a;
        if (tbl_len[id] == 0) begin
            e.send = 1'b0; e.instr = '0; e.last = 1'b1; e.id = id;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < int'(tbl_len[id]); i++) begin
                a = tbl_start[id] + 10'(i);
                e.send = 1'b1; e.instr = tmem[a]; e.last = (i == int'(tbl_len[id]) - 1); e.id = id;
                exp_q.push_back(e);
            end
        end
        outstanding++;
    endtask

    task automatic monitor();
        exp_t e;
        if (O_Req_Ld && !I_Stall) addr_log.push_back(O_Address_Ld);
        if (O_Req_Ld) ld_cyc++;
        if (post_end > 0) begin
            if (O_Req_Ld) ld_after_end++;
            post_end--;
        end
        if (O_Send || O_End) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'({O_Send, O_End}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("send", 64'(O_Send), 64'(e.send));
                if (e.send) chk("instr", O_Instr, e.instr);
                chk("end", 64'(O_End), 64'(e.last));
                chk("thread_id", 64'(O_ThreadID), 64'(e.id));
                if (e.last) outstanding--;
            end
            if (O_Send) begin
                send_cnt++;
                if (first_send_cyc < 0) first_send_cyc = cyc_no;
            end
            if (O_End) begin
                end_cnt++;
                if (O_Req_Ld) ld_after_end++;
                post_end = 2;
            end
        end
    endtask

    // One clock: thread memory returns the word addressed at the previous edge, MapMan answers lookups.
    task automatic cyc();
        pr = O_Req_Ld;
        pa = O_Address_Ld;
        @(posedge clock);
        #1;
        cyc_no++;
        if (pr) I_Instr_Ld = tmem[pa];
        I_Req = 1'b0;
        if (I_Ack_Lookup) begin
            I_Ack_Lookup = 1'b0;
        end else if (O_Req_Lookup) begin
            if (lk_wait == 0) begin
                I_Ack_Lookup = 1'b1;
                I_Start  = tbl_start[O_ThreadID_Lk];
                I_Length = tbl_len[O_ThreadID_Lk];
                ack_cyc  = cyc_no;
                lk_wait  = stall_rand ? int'($urandom_range(0, 2)) : 0;
            end else begin
                lk_wait--;
            end
        end
        if (stall_rand) I_Stall = ($urandom_range(0, 3) == 0);
        #1;
        monitor();
    endtask

    task automatic pulse_req(input logic [7:0] id, input logic accept);
        I_Req = 1'b1;
        I_ThreadID = id;
        if (accept) enqueue(id);
        cyc();
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while ((exp_q.size() != 0 || O_Busy) && k < limit) begin
            cyc();
            k++;
        end
        chk("drain_in_time", 64'(k < limit), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_lookup"}, 64'(O_Req_Lookup), 64'd0);
        chk({tag, "_req_ld"}, 64'(O_Req_Ld), 64'd0);
        chk({tag, "_addr_ld"}, 64'(O_Address_Ld), 64'd0);
        chk({tag, "_send"}, 64'(O_Send), 64'd0);
        chk({tag, "_instr"}, O_Instr, 64'd0);
        chk({tag, "_end"}, 64'(O_End), 64'd0);
        chk({tag, "_tid"}, 64'(O_ThreadID), 64'd0);
        chk({tag, "_tid_lk"}, 64'(O_ThreadID_Lk), 64'd0);
        chk({tag, "_busy"}, 64'(O_Busy), 64'd0);
        chk({tag, "_overflow"}, 64'(O_Overflow), 64'd0);
    endtask

    logic [9:0] exp_addr [4];
    int k, s0, e0;

    initial begin
        send_cnt = 0; end_cnt = 0; ld_cyc = 0; ld_after_end = 0; post_end = 0;
        first_send_cyc = -1; ack_cyc = 0; lk_wait = 0; outstanding = 0;
        for (int i = 0; i < 1024; i++) tmem[i] = {$urandom, $urandom};
        for (int i = 0; i < 256; i++) begin
            tbl_start[i] = 10'($urandom_range(0, 1023));
            tbl_len[i]   = 10'($urandom_range(0, 6));
        end
        tbl_start[5]  = 10'h010; tbl_len[5]  = 10'd3;
        tbl_start[7]  = 10'h3FE; tbl_len[7]  = 10'd4;
        tbl_len[9]    = 10'd5;
        tbl_len[11]   = 10'd0;
        tbl_len[20]   = 10'd12;
        for (int i = 21; i <= 26; i++) tbl_len[i] = 10'($urandom_range(1, 3));
        tbl_len[100]  = 10'd20;
        tbl_len[101]  = 10'd3;

        // Reset state
        repeat (2) @(posedge clock);
        #2;
        check_idle_outputs("reset");
        reset = 1'b1;
        cyc(); cyc();

        // T1: basic 3-word thread
        addr_log.delete(); first_send_cyc = -1; send_cnt = 0; end_cnt = 0;
        pulse_req(8'd5, 1'b1);
        wait_done(60);
        exp_addr[0] = 10'h010; exp_addr[1] = 10'h011; exp_addr[2] = 10'h012;
        chk("t1_addr_count", 64'(addr_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < addr_log.size(); i++) chk("t1_addr", 64'(addr_log[i]), 64'(exp_addr[i]));
        chk("t1_ack_to_send", 64'(first_send_cyc - ack_cyc), 64'd2);
        chk("t1_words", 64'(send_cnt), 64'd3);
        chk("t1_ends", 64'(end_cnt), 64'd1);

        // T2: address wrap
        addr_log.delete();
        pulse_req(8'd7, 1'b1);
        wait_done(60);
        exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
        chk("t2_addr_count", 64'(addr_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_addr", 64'(addr_log[i]), 64'(exp_addr[i]));

        // T3: three stall cycles after the second issue
        send_cnt = 0;
        pulse_req(8'd9, 1'b1);
        k = 0;
        while (send_cnt == 0 && k < 40) begin cyc(); k++; end
        chk("t3_first_word_in_time", 64'(k < 40), 64'd1);
        s0 = send_cnt;
        cyc();
        I_Stall = 1'b1;
        cyc(); chk("t3_req_ld_stall", 64'(O_Req_Ld), 64'd1);
        cyc(); chk("t3_req_ld_stall", 64'(O_Req_Ld), 64'd1);
        chk("t3_words_in_stall_window", 64'(send_cnt - s0), 64'd1);
        cyc(); chk("t3_req_ld_stall", 64'(O_Req_Ld), 64'd1);
        I_Stall = 1'b0;
        wait_done(60);
        chk("t3_words", 64'(send_cnt), 64'd5);

        // T4: empty thread
        ld_cyc = 0; send_cnt = 0; end_cnt = 0;
        pulse_req(8'd11, 1'b1);
        wait_done(60);
        chk("t4_no_load", 64'(ld_cyc), 64'd0);
        chk("t4_no_send", 64'(send_cnt), 64'd0);
        chk("t4_one_end", 64'(end_cnt), 64'd1);
        chk("t4_idle", 64'(O_Busy), 64'd0);

        // T5: queue overflow while a long thread is loading
        end_cnt = 0;
        pulse_req(8'd20, 1'b1);
        k = 0;
        while (!O_Req_Ld && k < 40) begin cyc(); k++; end
        chk("t5_loading", 64'(O_Req_Ld), 64'd1);
        chk("t5_no_overflow_yet", 64'(O_Overflow), 64'd0);
        for (int i = 0; i < 6; i++) pulse_req(8'(21 + i), (i < 4) ? 1'b1 : 1'b0);
        chk("t5_overflow", 64'(O_Overflow), 64'd1);
        wait_done(300);
        chk("t5_threads", 64'(end_cnt), 64'd5);
        chk("t5_overflow_sticky", 64'(O_Overflow), 64'd1);

        // Randomized traffic with stalls and variable lookup latency
        stall_rand = 1'b1;
        e0 = end_cnt;
        for (int n = 0; n < 40; n++) begin
            k = 0;
            while (outstanding >= 4 && k < 200) begin cyc(); k++; end
            repeat ($urandom_range(0, 4)) cyc();
            pulse_req(8'(40 + n), 1'b1);
        end
        wait_done(3000);
        chk("rand_threads", 64'(end_cnt - e0), 64'd40);
        stall_rand = 1'b0;
        I_Stall = 1'b0;
        repeat (3) cyc();

        // T6: asynchronous reset mid-load, then a clean restart
        send_cnt = 0;
        pulse_req(8'd100, 1'b1);
        k = 0;
        while (send_cnt == 0 && k < 40) begin cyc(); k++; end
        chk("t6_mid_load", 64'(O_Req_Ld), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        exp_q.delete();
        outstanding = 0;
        I_Ack_Lookup = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        end_cnt = 0; send_cnt = 0;
        pulse_req(8'd101, 1'b1);
        wait_done(60);
        chk("t6_restart_words", 64'(send_cnt), 64'd3);
        chk("t6_restart_end", 64'(end_cnt), 64'd1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("ld_low_after_end", 64'(ld_after_end), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
